// File: rtl/kaktovik_reader.sv
// kaktovik_reader
// ---------------
// Reads a multi-digit Kaktovik (base-20) number, one digit per input beat,
// most-significant digit first. Each beat carries one 8-bit segment pattern.
// The pattern is first normalised to active-high using AL, then decoded to a
// digit 0..19 and folded into a running binary value (VALUE = VALUE*20 + d).
// The beat flagged with ILAST closes the number. The result is then presented
// on a valid/ready output handshake.
//
// Ports
//   CLK     in   1   rising-edge clock
//   RST     in   1   synchronous active-high reset
//   AL      in   1   segment polarity (1 = active-high, 0 = active-low)
//   SEG     in   8   segment pattern, bit0 = a ... bit7 = h
//   IV      in   1   input valid (qualifies SEG, ILAST, AL)
//   ILAST   in   1   this beat is the least-significant digit
//   IR      out  1   input ready (accumulating)
//   VALUE   out 18   accumulated binary value
//   DIGITS  out  3   digits accepted into VALUE (0..4)
//   ERR     out  1   an unrecognised pattern was seen in this number
//   OVF     out  1   more than four digits were seen in this number
//   OV      out  1   output valid (result complete)
//   ORDY    in   1   output ready (consumer takes the result)
//
// The value register is 18 bits wide. Four digits of 19 give 159999, which
// is below 2^18, so the multiply-accumulate never truncates.

module kaktovik_reader (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AL,
  input  logic [7:0]  SEG,
  input  logic        IV,
  input  logic        ILAST,
  output logic        IR,
  output logic [17:0] VALUE,
  output logic [2:0]  DIGITS,
  output logic        ERR,
  output logic        OVF,
  output logic        OV,
  input  logic        ORDY
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  state_t      state_reg;
  logic [17:0] value_reg;
  logic [2:0]  digits_reg;
  logic        err_reg;
  logic        ovf_reg;

  // Decoded beat
  logic [7:0]  raw;
  logic        digit_ok;
  logic [4:0]  digit;
  logic        accept;
  logic [17:0] value_times20;
  logic [17:0] value_next;

  // Map an active-high pattern to {recognised, digit}. Unrecognised patterns
  // return digit 0 so that they contribute nothing to the value. The
  // extended-range shapes (C0, C1, C7, CF, DF, A0, A1, A7, AF, BF) are not
  // listed here, so they fall into the default branch.
  function automatic logic [5:0] decode_pattern(input logic [7:0] pat);
    logic [5:0] res;
    case (pat)
      8'h00: res = {1'b1, 5'd0};   // blanked digit reads as zero
      8'h04: res = {1'b1, 5'd0};
      8'h01: res = {1'b1, 5'd1};
      8'h07: res = {1'b1, 5'd2};
      8'h0F: res = {1'b1, 5'd3};
      8'h1F: res = {1'b1, 5'd4};
      8'h20: res = {1'b1, 5'd5};
      8'h21: res = {1'b1, 5'd6};
      8'h27: res = {1'b1, 5'd7};
      8'h2F: res = {1'b1, 5'd8};
      8'h3F: res = {1'b1, 5'd9};
      8'h60: res = {1'b1, 5'd10};
      8'h61: res = {1'b1, 5'd11};
      8'h67: res = {1'b1, 5'd12};
      8'h6F: res = {1'b1, 5'd13};
      8'h7F: res = {1'b1, 5'd14};
      8'hE0: res = {1'b1, 5'd15};
      8'hE1: res = {1'b1, 5'd16};
      8'hE7: res = {1'b1, 5'd17};
      8'hEF: res = {1'b1, 5'd18};
      8'hFF: res = {1'b1, 5'd19};
      default: res = {1'b0, 5'd0};
    endcase
    return res;
  endfunction

  // Normalise polarity. Active-low segments are inverted before the lookup.
  assign raw = SEG ^ {8{~AL}};
  assign {digit_ok, digit} = decode_pattern(raw);

  // IR and OV are derived from the state. They are gated by RST so that both
  // read 0 throughout reset, even before the first reset edge. Once RST drops
  // with the state already in ACC, IR is 1 in the very next cycle.
  assign IR = (state_reg == ST_ACC) && !RST;
  assign OV = (state_reg == ST_OUT) && !RST;

  assign accept = IV && IR;

  // VALUE*20 is formed as VALUE*16 + VALUE*4. The shifted bits that drop off
  // are always zero, because VALUE never exceeds 7999 when a fourth digit is
  // folded in.
  assign value_times20 = {value_reg[13:0], 4'b0000} + {value_reg[15:0], 2'b00};
  assign value_next    = value_times20 + {13'd0, digit};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_ACC;
      value_reg  <= '0;
      digits_reg <= '0;
      err_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_ACC: begin
          if (accept) begin
            if (digits_reg < MAX_DIGITS) begin
              value_reg  <= value_next;
              digits_reg <= digits_reg + 3'd1;
            end else begin
              // A fifth or later digit: the value is frozen, and the number
              // is flagged as overflowed.
              ovf_reg <= 1'b1;
            end
            if (!digit_ok) begin
              err_reg <= 1'b1;
            end
            // The closing beat ends the number whether or not it overflowed.
            if (ILAST) begin
              state_reg <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          // The result holds until it is taken. It is then cleared, ready
          // for the next number.
          if (ORDY) begin
            state_reg  <= ST_ACC;
            value_reg  <= '0;
            digits_reg <= '0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_ACC;
        end
      endcase
    end
  end

  assign VALUE  = value_reg;
  assign DIGITS = digits_reg;
  assign ERR    = err_reg;
  assign OVF    = ovf_reg;

endmodule

// File: tb/tb_kaktovik_reader.sv
// Directed testbench for kaktovik_reader. Each scenario task drives its own
// beats and compares outputs against hand-computed values, sampling 1 time
// unit after the rising edge.

module tb_kaktovik_reader;

  logic        CLK;
  logic        RST;
  logic        AL;
  logic [7:0]  SEG;
  logic        IV;
  logic        ILAST;
  logic        IR;
  logic [17:0] VALUE;
  logic [2:0]  DIGITS;
  logic        ERR;
  logic        OVF;
  logic        OV;
  logic        ORDY;

  int checks = 0;
  int errors = 0;

  kaktovik_reader dut (
    .CLK    (CLK),
    .RST    (RST),
    .AL     (AL),
    .SEG    (SEG),
    .IV     (IV),
    .ILAST  (ILAST),
    .IR     (IR),
    .VALUE  (VALUE),
    .DIGITS (DIGITS),
    .ERR    (ERR),
    .OVF    (OVF),
    .OV     (OV),
    .ORDY   (ORDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents one beat for a single clock cycle.
  task automatic send_beat(input logic al, input logic [7:0] seg, input logic last);
    AL = al; SEG = seg; ILAST = last; IV = 1'b1;
    step();
    IV = 1'b0; ILAST = 1'b0;
    $display("beat al=%0d seg=%02h last=%0d -> value=%0d digits=%0d err=%0d ovf=%0d ov=%0d",
             al, seg, last, VALUE, DIGITS, ERR, OVF, OV);
  endtask

  // Hands the pending result to the consumer for one cycle.
  task automatic consume();
    ORDY = 1'b1;
    step();
    ORDY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; IV = 1'b0; ILAST = 1'b0; AL = 1'b1; SEG = 8'h00; ORDY = 1'b0;
    #1;
    checks++; if (IR !== 1'b0) begin errors++; $display("FAIL reset_ir_pre got=%0d want=0", IR); end
    step(); step();
    checks++; if (IR !== 1'b0) begin errors++; $display("FAIL reset_ir got=%0d want=0", IR); end
    checks++; if (OV !== 1'b0) begin errors++; $display("FAIL reset_ov got=%0d want=0", OV); end
    checks++; if (VALUE !== 18'd0) begin errors++; $display("FAIL reset_value got=%0d want=0", VALUE); end
    checks++; if (DIGITS !== 3'd0) begin errors++; $display("FAIL reset_digits got=%0d want=0", DIGITS); end
    checks++; if (ERR !== 1'b0 || OVF !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0d%0d want=00", ERR, OVF); end
    RST = 1'b0;
    #1;
    checks++; if (IR !== 1'b1) begin errors++; $display("FAIL reset_ir_release got=%0d want=1", IR); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    send_beat(1'b1, 8'h01, 1'b0);
    checks++; if (OV !== 1'b0 || VALUE !== 18'd1) begin errors++; $display("FAIL basic_partial got ov=%0d value=%0d want ov=0 value=1", OV, VALUE); end
    send_beat(1'b1, 8'hFF, 1'b1);
    checks++; if (OV !== 1'b1) begin errors++; $display("FAIL basic_ov got=%0d want=1", OV); end
    checks++; if (IR !== 1'b0) begin errors++; $display("FAIL basic_ir got=%0d want=0", IR); end
    checks++; if (VALUE !== 18'd39) begin errors++; $display("FAIL basic_value got=%0d want=39", VALUE); end
    checks++; if (DIGITS !== 3'd2) begin errors++; $display("FAIL basic_digits got=%0d want=2", DIGITS); end
    checks++; if (ERR !== 1'b0 || OVF !== 1'b0) begin errors++; $display("FAIL basic_flags got=%0d%0d want=00", ERR, OVF); end
    consume();
  endtask

  task automatic test_active_low();
    send_beat(1'b0, 8'hD8, 1'b1);   // ~D8 = 27 -> 7
    checks++; if (OV !== 1'b1 || VALUE !== 18'd7) begin errors++; $display("FAIL al0_value got ov=%0d value=%0d want ov=1 value=7", OV, VALUE); end
    checks++; if (DIGITS !== 3'd1 || ERR !== 1'b0) begin errors++; $display("FAIL al0_digits got digits=%0d err=%0d want 1/0", DIGITS, ERR); end
    consume();
    // An active-low blank (FF -> 00) counts as a zero digit.
    send_beat(1'b0, 8'hFE, 1'b0);   // ~FE = 01 -> 1
    send_beat(1'b0, 8'hFF, 1'b1);   // blank -> 0
    checks++; if (VALUE !== 18'd20 || DIGITS !== 3'd2 || ERR !== 1'b0) begin errors++; $display("FAIL al0_blank got value=%0d digits=%0d err=%0d want 20/2/0", VALUE, DIGITS, ERR); end
    consume();
  endtask

  task automatic test_overflow();
    send_beat(1'b1, 8'h01, 1'b0);
    send_beat(1'b1, 8'h00, 1'b0);
    send_beat(1'b1, 8'h04, 1'b0);
    send_beat(1'b1, 8'h00, 1'b0);
    checks++; if (OVF !== 1'b0 || DIGITS !== 3'd4 || OV !== 1'b0) begin errors++; $display("FAIL ovf_four got ovf=%0d digits=%0d ov=%0d want 0/4/0", OVF, DIGITS, OV); end
    send_beat(1'b1, 8'h00, 1'b1);
    checks++; if (OV !== 1'b1 || VALUE !== 18'd8000) begin errors++; $display("FAIL ovf_value got ov=%0d value=%0d want ov=1 value=8000", OV, VALUE); end
    checks++; if (DIGITS !== 3'd4 || OVF !== 1'b1 || ERR !== 1'b0) begin errors++; $display("FAIL ovf_flags got digits=%0d ovf=%0d err=%0d want 4/1/0", DIGITS, OVF, ERR); end
    consume();
    checks++; if (OVF !== 1'b0 || OV !== 1'b0 || IR !== 1'b1) begin errors++; $display("FAIL ovf_clear got ovf=%0d ov=%0d ir=%0d want 0/0/1", OVF, OV, IR); end
  endtask

  task automatic test_max_value();
    for (int i = 0; i < 4; i++) send_beat(1'b1, 8'hFF, (i == 3) ? 1'b1 : 1'b0);
    checks++; if (VALUE !== 18'd159999 || DIGITS !== 3'd4 || OVF !== 1'b0) begin errors++; $display("FAIL max_value got value=%0d digits=%0d ovf=%0d want 159999/4/0", VALUE, DIGITS, OVF); end
    consume();
  endtask

  task automatic test_invalid();
    send_beat(1'b1, 8'h02, 1'b0);
    send_beat(1'b1, 8'h21, 1'b1);
    checks++; if (ERR !== 1'b1 || VALUE !== 18'd6 || DIGITS !== 3'd2) begin errors++; $display("FAIL invalid got err=%0d value=%0d digits=%0d want 1/6/2", ERR, VALUE, DIGITS); end
    consume();
    send_beat(1'b1, 8'hC0, 1'b1);   // extended-range shape is rejected
    checks++; if (ERR !== 1'b1 || VALUE !== 18'd0 || DIGITS !== 3'd1) begin errors++; $display("FAIL invalid_ext got err=%0d value=%0d digits=%0d want 1/0/1", ERR, VALUE, DIGITS); end
    consume();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL invalid_clear got err=%0d want 0", ERR); end
  endtask

  task automatic test_backpressure();
    send_beat(1'b1, 8'h2F, 1'b1);   // 8
    AL = 1'b1; SEG = 8'h07; IV = 1'b1; ILAST = 1'b1; ORDY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (OV !== 1'b1 || IR !== 1'b0) begin errors++; $display("FAIL bp_hold_hs cycle=%0d got ov=%0d ir=%0d want 1/0", c, OV, IR); end
      checks++; if (VALUE !== 18'd8 || DIGITS !== 3'd1) begin errors++; $display("FAIL bp_hold_data cycle=%0d got value=%0d digits=%0d want 8/1", c, VALUE, DIGITS); end
    end
    IV = 1'b0; ILAST = 1'b0;
    consume();
    checks++; if (IR !== 1'b1 || VALUE !== 18'd0 || OV !== 1'b0 || DIGITS !== 3'd0) begin errors++; $display("FAIL bp_release got ir=%0d value=%0d ov=%0d digits=%0d want 1/0/0/0", IR, VALUE, OV, DIGITS); end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_number();
    send_beat(1'b1, 8'h01, 1'b0);
    send_beat(1'b1, 8'h07, 1'b0);
    checks++; if (VALUE !== 18'd22 || DIGITS !== 3'd2) begin errors++; $display("FAIL midrst_partial got value=%0d digits=%0d want 22/2", VALUE, DIGITS); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    checks++; if (VALUE !== 18'd0 || DIGITS !== 3'd0 || OV !== 1'b0 || IR !== 1'b1) begin errors++; $display("FAIL midrst_clear got value=%0d digits=%0d ov=%0d ir=%0d want 0/0/0/1", VALUE, DIGITS, OV, IR); end
    send_beat(1'b1, 8'h0F, 1'b1);
    checks++; if (VALUE !== 18'd3 || DIGITS !== 3'd1 || OV !== 1'b1) begin errors++; $display("FAIL midrst_next got value=%0d digits=%0d ov=%0d want 3/1/1", VALUE, DIGITS, OV); end
    // Reset while a result is pending discards it.
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    checks++; if (OV !== 1'b0 || VALUE !== 18'd0 || IR !== 1'b1) begin errors++; $display("FAIL outrst got ov=%0d value=%0d ir=%0d want 0/0/1", OV, VALUE, IR); end
  endtask

  task automatic test_back_to_back();
    send_beat(1'b1, 8'h6F, 1'b1);   // 13
    checks++; if (VALUE !== 18'd13) begin errors++; $display("FAIL b2b_first got=%0d want=13", VALUE); end
    consume();
    send_beat(1'b1, 8'h1F, 1'b0);   // 4
    send_beat(1'b1, 8'hE7, 1'b1);   // 17 -> 4*20+17 = 97
    checks++; if (VALUE !== 18'd97 || DIGITS !== 3'd2) begin errors++; $display("FAIL b2b_second got value=%0d digits=%0d want 97/2", VALUE, DIGITS); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_active_low();
    test_overflow();
    test_max_value();
    test_invalid();
    test_backpressure();
    test_reset_mid_number();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kaktovik_reader.md
KAKTOVIK_READER -- requirements
Module: kaktovik_reader

Interface
REQ-001 The block SHALL have one clock, CLK, and a synchronous active-high reset, RST.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 AL  in  1  segment polarity: 1 = active-high segments, 0 = active-low segments.
REQ-005 SEG  in  8  one digit's segment pattern, bit0 = segment a ... bit7 = segment h.
REQ-006 IV  in  1  input valid: SEG, ILAST and AL are valid this cycle.
REQ-007 ILAST  in  1  the current input beat is the least-significant digit of the number.
REQ-008 IR  out  1  input ready.
REQ-009 VALUE  out  18  accumulated binary value of the number.
REQ-010 DIGITS  out  3  count of digits accepted into VALUE, 0..4.
REQ-011 ERR  out  1  an unrecognised pattern was received in this number.
REQ-012 OVF  out  1  more than 4 digits were received in this number.
REQ-013 OV  out  1  output valid: VALUE, DIGITS, ERR and OVF are complete.
REQ-014 ORDY  in  1  output ready.

Function
REQ-015 The block SHALL normalise each pattern as raw = SEG XOR {8{~AL}}, sampled on the accepting cycle.
REQ-016 The block SHALL decode raw to digit d per this table (hex): 00->0, 04->0, 01->1, 07->2, 0F->3, 1F->4, 20->5, 21->6, 27->7, 2F->8, 3F->9, 60->10, 61->11, 67->12, 6F->13, 7F->14, E0->15, E1->16, E7->17, EF->18, FF->19.
REQ-017 Any other raw pattern, including the extended-range patterns C0/C1/C7/CF/DF/A0/A1/A7/AF/BF, SHALL set ERR and SHALL be accumulated as d = 0.
REQ-018 The block SHALL have two states: ACC (IR = 1, OV = 0) and OUT (IR = 0, OV = 1).
REQ-019 A beat SHALL be accepted only when IV = 1 and IR = 1; IV while IR = 0 SHALL be ignored.
REQ-020 On an accepted beat with DIGITS < 4: VALUE <= VALUE*20 + d, computed in 18 bits without truncation, and DIGITS <= DIGITS + 1.
REQ-021 On an accepted beat with DIGITS = 4: VALUE and DIGITS SHALL hold and OVF SHALL be set.
REQ-022 ERR and OVF SHALL be sticky until the result is consumed or the block is reset.
REQ-023 An accepted beat with ILAST = 1 SHALL move the block ACC->OUT; OV SHALL assert the cycle after that beat and include its digit (latency 1).
REQ-024 In OUT, VALUE, DIGITS, ERR and OVF SHALL be held stable while ORDY = 0.
REQ-025 In OUT, when ORDY = 1 the block SHALL go to ACC next cycle and clear VALUE, DIGITS, ERR and OVF to 0.
REQ-026 Digit 0 via pattern 00 (blanked) and via pattern 04 SHALL be equivalent and SHALL count as a digit.
REQ-027 An ILAST beat at DIGITS = 4 SHALL set OVF and SHALL still move the block to OUT.

Reset
REQ-028 While RST = 1: state = ACC, VALUE = 0, DIGITS = 0, ERR = 0, OVF = 0, OV = 0 and IR = 0.
REQ-029 IR SHALL be 1 in the first cycle after RST deasserts.
REQ-030 RST asserted mid-number or in OUT SHALL discard all partial or pending results.

Verification
REQ-031 AL=1, beats 01, then FF with ILAST -> OV=1, VALUE=39, DIGITS=2, ERR=0, OVF=0.
REQ-032 AL=0, single beat SEG=D8 with ILAST -> VALUE=7, DIGITS=1, ERR=0.
REQ-033 AL=1, five beats 01,00,04,00,00, ILAST on the fifth -> VALUE=8000, DIGITS=4, OVF=1.
REQ-034 AL=1, beats 02 (invalid), then 21 with ILAST -> ERR=1, VALUE=6, DIGITS=2.
REQ-035 Result pending with ORDY=0 for 3 cycles while IV=1 -> outputs stable, IR=0, no beat accepted; ORDY=1 -> next cycle IR=1, VALUE=0.
REQ-036 Two digits accepted, then RST for 1 cycle -> VALUE=0, DIGITS=0, OV=0; the next number decodes independently.
